// File: rtl/multi_channel_timestamper_if.sv
// Decoupled output stream of the multi-channel timestamper.
// The master side (the timestamper) drives valid and the payload fields,
// and the slave side (the consumer) drives ready.
interface multi_channel_timestamper_if #(
  parameter int DATA_WIDTH = 8,
  parameter int TIME_WIDTH = 64,
  parameter int CHAN_WIDTH = 2
);
  logic                  timestamped_valid;
  logic                  timestamped_ready;
  logic [DATA_WIDTH-1:0] timestamped_bits_data;
  logic [TIME_WIDTH-1:0] timestamped_bits_time;
  logic [CHAN_WIDTH-1:0] timestamped_bits_channel;

  modport master (
    output timestamped_valid,
    input  timestamped_ready,
    output timestamped_bits_data,
    output timestamped_bits_time,
    output timestamped_bits_channel
  );

  modport slave (
    input  timestamped_valid,
    output timestamped_ready,
    input  timestamped_bits_data,
    input  timestamped_bits_time,
    input  timestamped_bits_channel
  );
endinterface

// File: rtl/multi_channel_timestamper.sv
// Multi-channel timestamper.
// Every cycle each channel's value is compared with the value seen in the
// previous cycle. While enable is high, a difference is an event: the new
// value and the current cycle count are pushed into that channel's FIFO.
// The FIFOs are merged onto one valid/ready stream by a round-robin arbiter
// whose grant is frozen while the consumer stalls. Events that find their
// FIFO full are dropped and reported through the sticky overflow flags and
// the saturating drop counter.
// Optional build macro TIMESTAMPER_FATAL_ON_OVERFLOW_EN: when defined, a
// dropped event also stops simulation with $fatal (simulation-only code).
module multi_channel_timestamper #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int DEPTH        = 16,
  parameter int TIME_WIDTH   = 64
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] value,
  input  logic                               enable,
  input  logic                               clear_overflow,
  multi_channel_timestamper_if.master        ts,
  output logic [NUM_CHANNELS-1:0]            overflow,
  output logic [31:0]                        drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  // Free-running timestamp and per-channel change history
  logic [TIME_WIDTH-1:0] time_q;
  logic [DATA_WIDTH-1:0] prev_q [NUM_CHANNELS];

  // Per-channel FIFO storage and pointers (extra MSB tells full from empty)
  logic [DATA_WIDTH-1:0] mem_data_q [NUM_CHANNELS][DEPTH];
  logic [TIME_WIDTH-1:0] mem_time_q [NUM_CHANNELS][DEPTH];
  logic [PW-1:0]         wr_ptr_q   [NUM_CHANNELS];
  logic [PW-1:0]         wr_ptr_d   [NUM_CHANNELS];
  logic [PW-1:0]         rd_ptr_q   [NUM_CHANNELS];
  logic [PW-1:0]         rd_ptr_d   [NUM_CHANNELS];

  // Arbiter state
  logic [CW-1:0] rr_q;
  logic [CW-1:0] rr_d;
  logic [CW-1:0] grant_q;
  logic          lock_q;
  logic [CW-1:0] sel_s;
  logic          sel_found_s;
  logic [CW-1:0] grant_s;

  // Overflow reporting
  logic [NUM_CHANNELS-1:0] ovf_q;
  logic [NUM_CHANNELS-1:0] ovf_d;
  logic [31:0]             drop_q;
  logic [31:0]             drop_d;

  // Per-channel status and control
  logic [NUM_CHANNELS-1:0] empty_s;
  logic [NUM_CHANNELS-1:0] full_s;
  logic [NUM_CHANNELS-1:0] event_s;
  logic [NUM_CHANNELS-1:0] pop_s;
  logic [NUM_CHANNELS-1:0] push_s;
  logic [NUM_CHANNELS-1:0] drop_s;
  logic                    valid_s;
  logic                    hs_s;

  // Head-of-line fields of the granted FIFO
  logic [AW-1:0]         head_addr_s;
  logic [DATA_WIDTH-1:0] head_data_s;
  logic [TIME_WIDTH-1:0] head_time_s;

  // FIFO occupancy flags and change detection per channel
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      empty_s[c] = (wr_ptr_q[c] == rd_ptr_q[c]);
      full_s[c]  = (wr_ptr_q[c][AW] != rd_ptr_q[c][AW]) &&
                   (wr_ptr_q[c][AW-1:0] == rd_ptr_q[c][AW-1:0]);
      event_s[c] = enable && (value[c*DATA_WIDTH +: DATA_WIDTH] != prev_q[c]);
    end
  end

  // Round-robin search: first non-empty FIFO at or after the pointer
  always_comb begin : rr_select
    logic [CW-1:0] cand_v;
    logic          take_v;
    cand_v      = '0;
    take_v      = 1'b0;
    sel_s       = '0;
    sel_found_s = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      cand_v      = CW'((int'(rr_q) + i) % NUM_CHANNELS);
      take_v      = !sel_found_s && !empty_s[cand_v];
      sel_s       = take_v ? cand_v : sel_s;
      sel_found_s = sel_found_s | take_v;
    end
  end

  // Grant (held while a presented entry is stalled), handshake, FIFO control
  always_comb begin
    grant_s = lock_q ? grant_q : sel_s;
    valid_s = |(~empty_s);
    hs_s    = valid_s && ts.timestamped_ready;
    rr_d    = hs_s ? CW'((int'(grant_s) + 1) % NUM_CHANNELS) : rr_q;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      pop_s[c]    = hs_s && (grant_s == CW'(c));
      // A full FIFO still accepts when its head leaves in the same cycle
      push_s[c]   = event_s[c] && (!full_s[c] || pop_s[c]);
      drop_s[c]   = event_s[c] && full_s[c] && !pop_s[c];
      wr_ptr_d[c] = push_s[c] ? (wr_ptr_q[c] + PW'(1)) : wr_ptr_q[c];
      rd_ptr_d[c] = pop_s[c]  ? (rd_ptr_q[c] + PW'(1)) : rd_ptr_q[c];
    end
  end

  // Sticky flags and saturating drop count; a same-cycle drop beats clear
  always_comb begin : ovf_update
    logic [31:0] base_v;
    logic [31:0] ndrop_v;
    logic [32:0] sum_v;
    ovf_d   = (clear_overflow ? {NUM_CHANNELS{1'b0}} : ovf_q) | drop_s;
    base_v  = clear_overflow ? 32'd0 : drop_q;
    ndrop_v = 32'd0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      ndrop_v = ndrop_v + {31'd0, drop_s[c]};
    end
    sum_v  = {1'b0, base_v} + {1'b0, ndrop_v};
    drop_d = sum_v[32] ? 32'hFFFF_FFFF : sum_v[31:0];
  end

  // Read the head entry of the granted FIFO; payload is zero when idle
  always_comb begin
    head_addr_s = rd_ptr_q[grant_s][AW-1:0];
    head_data_s = mem_data_q[grant_s][head_addr_s];
    head_time_s = mem_time_q[grant_s][head_addr_s];
    ts.timestamped_valid        = valid_s;
    ts.timestamped_bits_data    = valid_s ? head_data_s : {DATA_WIDTH{1'b0}};
    ts.timestamped_bits_time    = valid_s ? head_time_s : {TIME_WIDTH{1'b0}};
    ts.timestamped_bits_channel = valid_s ? grant_s     : {CW{1'b0}};
  end

  // Timestamp counter and previous-value history (updated regardless of enable)
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      time_q <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        prev_q[c] <= '0;
      end
    end else begin
      time_q <= time_q + TIME_WIDTH'(1);
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        prev_q[c] <= value[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // FIFO pointers; reset empties every FIFO at once
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
      end
    end
  end

  // FIFO payload storage; contents are only meaningful between the pointers
  always_ff @(posedge clock) begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (push_s[c]) begin
        mem_data_q[c][wr_ptr_q[c][AW-1:0]] <= value[c*DATA_WIDTH +: DATA_WIDTH];
        mem_time_q[c][wr_ptr_q[c][AW-1:0]] <= time_q;
      end
    end
  end

  // Arbiter pointer and grant lock for a stalled consumer
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_q    <= '0;
      grant_q <= '0;
      lock_q  <= 1'b0;
    end else begin
      rr_q    <= rr_d;
      grant_q <= grant_s;
      lock_q  <= valid_s && !ts.timestamped_ready;
    end
  end

  // Overflow flags and drop counter registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q  <= '0;
      drop_q <= 32'd0;
    end else begin
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
    end
  end

  assign overflow   = ovf_q;
  assign drop_count = drop_q;

`ifdef TIMESTAMPER_FATAL_ON_OVERFLOW_EN
  // Stop simulation at the edge where an event is lost
  always @(posedge clock) begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (reset_n && drop_s[c]) begin
        $fatal(1, "multi_channel_timestamper: event dropped on channel %0d", c);
      end
    end
  end
`else
  // Drops are reported only through overflow and drop_count.
`endif

endmodule

// File: tb/tb_multi_channel_timestamper.sv
// Scoreboard bench for multi_channel_timestamper (4 channels, DEPTH 4).
// A queue-based reference model is updated at every rising edge from the
// driven inputs; a monitor compares the DUT stream and overflow state with
// the model on every falling edge. Directed scenarios are followed by a
// randomized phase that includes an asynchronous reset mid-stream.
module tb_multi_channel_timestamper;
  localparam int DW    = 8;
  localparam int NCH   = 4;
  localparam int DEPTH = 4;
  localparam int TW    = 64;
  localparam int CW    = 2;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [NCH*DW-1:0] value = '0;
  logic              enable = 1'b0;
  logic              clear_overflow = 1'b0;
  logic              ready = 1'b0;
  logic [NCH-1:0]    overflow;
  logic [31:0]       drop_count;

  multi_channel_timestamper_if #(.DATA_WIDTH(DW), .TIME_WIDTH(TW), .CHAN_WIDTH(CW)) ts_if ();
  assign ts_if.timestamped_ready = ready;

  multi_channel_timestamper #(
    .DATA_WIDTH(DW), .NUM_CHANNELS(NCH), .DEPTH(DEPTH), .TIME_WIDTH(TW)
  ) dut (
    .clock(clock), .reset_n(reset_n), .value(value), .enable(enable),
    .clear_overflow(clear_overflow), .ts(ts_if), .overflow(overflow),
    .drop_count(drop_count)
  );

  initial forever #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b1;

  // cycle index since reset release
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [DW-1:0] d; logic [TW-1:0] t; } ent_t;
  ent_t          m_q [NCH][$];
  logic [DW-1:0] m_prev [NCH];
  logic [TW-1:0] m_time;
  int            m_rr, m_grant;
  bit            m_lock;
  logic [NCH-1:0] m_ovf;
  longint        m_cnt;

  function automatic bit model_any();
    for (int c = 0; c < NCH; c++) if (m_q[c].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int pick();
    if (m_lock) return m_grant;
    for (int i = 0; i < NCH; i++) begin
      int c;
      c = (m_rr + i) % NCH;
      if (m_q[c].size() > 0) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_q[c].delete();
      m_prev[c] = '0;
    end
    m_time = '0; m_rr = 0; m_grant = 0; m_lock = 1'b0; m_ovf = '0; m_cnt = 0;
  endtask

  task automatic model_step();
    int g;
    bit any, hs;
    logic [DW-1:0] v;
    any = model_any();
    g   = pick();
    hs  = any && ready;
    if (hs) begin
      void'(m_q[g].pop_front());
      m_rr = (g + 1) % NCH;
    end
    if (clear_overflow) begin
      m_ovf = '0;
      m_cnt = 0;
    end
    for (int c = 0; c < NCH; c++) begin
      v = value[c*DW +: DW];
      if (enable && v != m_prev[c]) begin
        if (m_q[c].size() < DEPTH) m_q[c].push_back(ent_t'{d: v, t: m_time});
        else begin
          m_ovf[c] = 1'b1;
          if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
        end
      end
      m_prev[c] = v;
    end
    m_lock  = any && !ready;
    m_grant = g;
    m_time  = m_time + 64'd1;
  endtask

  initial begin : model_proc
    model_reset();
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) model_reset();
      else          model_step();
    end
  end

  // ---------------- monitor / scoreboard compare ----------------
  initial begin : monitor
    int g;
    ent_t e;
    forever begin
      @(negedge clock);
      if (reset_n === 1'b1 && mon_en) begin
        if (model_any()) begin
          g = pick();
          e = m_q[g][0];
          chk("valid", ts_if.timestamped_valid, 1'b1);
          chk("channel", ts_if.timestamped_bits_channel, g);
          chk("data", ts_if.timestamped_bits_data, e.d);
          chk("time", ts_if.timestamped_bits_time, e.t);
        end else begin
          chk("valid_idle", ts_if.timestamped_valid, 1'b0);
          chk("data_idle", ts_if.timestamped_bits_data, 8'h00);
        end
        chk("overflow", overflow, m_ovf);
        chk("drop_count", drop_count, m_cnt);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  task automatic tick(); @(negedge clock); endtask
  task automatic wait_cyc(input int t); while (cyc < t) @(negedge clock); endtask
  task automatic set_ch(input int c, input logic [DW-1:0] v); value[c*DW +: DW] = v; endtask

  initial begin : driver
    int rdy_pct;
    // reset state
    repeat (2) tick();
    chk("rst_valid", ts_if.timestamped_valid, 1'b0);
    chk("rst_data", ts_if.timestamped_bits_data, 8'h00);
    chk("rst_time", ts_if.timestamped_bits_time, 64'd0);
    chk("rst_chan", ts_if.timestamped_bits_channel, 2'd0);
    chk("rst_ovf", overflow, 4'b0000);
    chk("rst_cnt", drop_count, 32'd0);
    reset_n = 1'b1; enable = 1'b1; ready = 1'b1;

    // single change on channel 3 in cycle 10
    wait_cyc(10); set_ch(3, 8'h5A);
    tick();
    chk("t1_valid", ts_if.timestamped_valid, 1'b1);
    chk("t1_chan", ts_if.timestamped_bits_channel, 2'd3);
    chk("t1_data", ts_if.timestamped_bits_data, 8'h5A);
    chk("t1_time", ts_if.timestamped_bits_time, 64'd10);
    tick();
    chk("t1_valid_once", ts_if.timestamped_valid, 1'b0);

    // all four channels change in cycle 20, pointer is back at 0
    wait_cyc(20); value = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int i = 0; i < NCH; i++) begin
      tick();
      chk("t2_chan", ts_if.timestamped_bits_channel, i);
      chk("t2_time", ts_if.timestamped_bits_time, 64'd20);
    end

    // backpressure: channel 2 then channel 1 change while stalled
    wait_cyc(30); ready = 1'b0; set_ch(2, 8'h77);
    for (int k = 31; k <= 36; k++) begin
      tick();
      chk("t3_hold_chan", ts_if.timestamped_bits_channel, 2'd2);
      chk("t3_hold_data", ts_if.timestamped_bits_data, 8'h77);
      chk("t3_hold_time", ts_if.timestamped_bits_time, 64'd30);
      if (k == 31) set_ch(1, 8'h66);
    end
    ready = 1'b1;
    tick();
    chk("t3_second_chan", ts_if.timestamped_bits_channel, 2'd1);
    chk("t3_second_time", ts_if.timestamped_bits_time, 64'd31);
    tick();
    chk("t3_drained", ts_if.timestamped_valid, 1'b0);

    // overflow: six toggles into a four-deep FIFO
    wait_cyc(40); ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      set_ch(0, 8'hA0 + 8'(k));
      tick();
    end
    chk("t4_ovf", overflow, 4'b0001);
    chk("t4_cnt", drop_count, 32'd2);
    chk("t4_head_time", ts_if.timestamped_bits_time, 64'd40);
    ready = 1'b1;
    wait_cyc(50);
    chk("t4_drained", ts_if.timestamped_valid, 1'b0);

    // clear pulse without a drop
    wait_cyc(52); clear_overflow = 1'b1;
    tick(); clear_overflow = 1'b0;
    chk("clr_ovf", overflow, 4'b0000);
    chk("clr_cnt", drop_count, 32'd0);

    // full FIFO with pop and push in the same cycle
    wait_cyc(55); ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_ch(0, 8'hB0 + 8'(k));
      tick();
    end
    ready = 1'b1; set_ch(0, 8'hB4);
    tick();
    chk("t5_ovf", overflow, 4'b0000);
    chk("t5_cnt", drop_count, 32'd0);
    chk("t5_head", ts_if.timestamped_bits_data, 8'hB1);
    wait_cyc(65);
    chk("t5_drained", ts_if.timestamped_valid, 1'b0);

    // clear coincident with a drop
    wait_cyc(70); ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      set_ch(1, 8'hC0 + 8'(k));
      tick();
    end
    chk("t6_cnt_before", drop_count, 32'd2);
    clear_overflow = 1'b1; set_ch(1, 8'hC6);
    tick(); clear_overflow = 1'b0;
    chk("t6_ovf", overflow, 4'b0010);
    chk("t6_cnt", drop_count, 32'd1);
    ready = 1'b1;
    wait_cyc(85);
    chk("t6_drained", ts_if.timestamped_valid, 1'b0);

    // randomized traffic
    rdy_pct = 80;
    for (int k = 0; k < 1000; k++) begin
      if (k % 100 == 0) rdy_pct = $urandom_range(0, 100);
      ready  = ($urandom_range(0, 99) < rdy_pct);
      enable = ($urandom_range(0, 7) != 0);
      clear_overflow = ($urandom_range(0, 49) == 0);
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 2) == 0) set_ch(c, 8'($urandom_range(0, 255)));
      tick();
    end

    // asynchronous reset while entries are buffered
    clear_overflow = 1'b0; enable = 1'b1; ready = 1'b0;
    set_ch(0, 8'h3C); set_ch(2, 8'hC3);
    tick();
    set_ch(0, 8'h4D); set_ch(2, 8'hD4);
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", ts_if.timestamped_valid, 1'b0);
    chk("arst_data", ts_if.timestamped_bits_data, 8'h00);
    chk("arst_time", ts_if.timestamped_bits_time, 64'd0);
    chk("arst_ovf", overflow, 4'b0000);
    chk("arst_cnt", drop_count, 32'd0);
    tick(); tick();
    reset_n = 1'b1; enable = 1'b0; ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("arst_no_replay", ts_if.timestamped_valid, 1'b0);
    end

    for (int k = 0; k < 800; k++) begin
      if (k % 80 == 0) rdy_pct = $urandom_range(0, 100);
      ready  = ($urandom_range(0, 99) < rdy_pct);
      enable = ($urandom_range(0, 5) != 0);
      clear_overflow = ($urandom_range(0, 39) == 0);
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 1) == 0) set_ch(c, 8'($urandom_range(0, 255)));
      tick();
    end

    // drain
    enable = 1'b0; ready = 1'b1; clear_overflow = 1'b0;
    repeat (NCH * DEPTH + 4) tick();
    chk("final_drained", ts_if.timestamped_valid, 1'b0);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_channel_timestamper.md
Name: multi_channel_timestamper

Overview:
- Samples NUM_CHANNELS reference signals every clock and detects value changes per channel.
- Tags each change with a free-running cycle-count timestamp and buffers it in a per-channel FIFO of DEPTH entries.
- Merges the FIFOs onto one decoupled (data, time, channel) stream through a round-robin arbiter.
- Overflow is reported through sticky flags and a drop counter; the block does not abort simulation. It is the parametrised, synthesizable successor to the single-channel timestamper used in model-vs-reference comparison benches.

Parameters:
- DATA_WIDTH, 8: width of each channel's sampled value.
- NUM_CHANNELS, 4: number of independent reference channels (>=1).
- DEPTH, 16: entries per channel FIFO; power of two, >=2.
- TIME_WIDTH, 64: timestamp width; the counter wraps modulo 2^TIME_WIDTH.

Ports:
- clock  in  1  single block clock.
- reset_n  in  1  asynchronous, active-low reset.
- value  in  NUM_CHANNELS*DATA_WIDTH  channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- enable  in  1  capture enable.
- clear_overflow  in  1  single-cycle pulse; clears overflow and drop_count.
- timestamped_valid  out  1  output entry available.
- timestamped_ready  in  1  consumer accepts the entry.
- timestamped_bits_data  out  DATA_WIDTH  captured value.
- timestamped_bits_time  out  TIME_WIDTH  cycle count at which the change was sampled.
- timestamped_bits_channel  out  max(1,$clog2(NUM_CHANNELS))  source channel index.
- overflow  out  NUM_CHANNELS  sticky per-channel drop flag.
- drop_count  out  32  total dropped events, saturating at 0xFFFFFFFF.

Behaviour:

Reset (reset_n low, asynchronous):
- time counter = 0; all prev registers = 0; all FIFOs empty; RR pointer = 0.
- Outputs: timestamped_valid = 0; bits_data, bits_time and bits_channel = 0; overflow = 0; drop_count = 0.
- Reset asserted mid-operation discards all buffered entries immediately. Nothing is replayed afterwards.

Time counter:
- Increments by 1 on every clock edge after reset release, wrapping at 2^TIME_WIDTH.
- The value presented during cycle t is T(t). The first cycle after release has T = 0.

Change detection:
- prev_c loads value_c every cycle, regardless of enable.
- Event on channel c in cycle t when enable=1 and value_c != prev_c.
- Because prev resets to 0, a nonzero value in the first enabled cycle is an event.
- The captured entry is {value_c, T(t)}. It is written at the edge ending cycle t.
- Latency: timestamped_valid can assert no earlier than cycle t+1.

FIFO (per channel, pointer width log2(DEPTH)+1):
- Push is accepted if the FIFO is not full, or if the same FIFO is popped in the same cycle (pop-before-push on full).
- Otherwise the event is dropped: overflow[c] is set and drop_count increments by the number of channels dropping that cycle, saturating.
- Order within a channel is preserved. No ordering is guaranteed across channels.

Arbiter / output:
- Selects the first non-empty FIFO at or after the RR pointer. Outputs present that FIFO's head combinationally.
- Grant lock: while timestamped_valid=1 and timestamped_ready=0, the granted channel and all output bits hold stable, even if other FIFOs fill.
- On handshake (valid & ready): pop the granted FIFO, then move the RR pointer to granted+1 mod NUM_CHANNELS.
- timestamped_valid = any FIFO non-empty. When valid=0, the bits outputs are don't-care but drive 0.
- Sustained throughput is one entry per cycle.

Overflow clear:
- clear_overflow=1 clears overflow and drop_count at the next edge.
- If a drop occurs in the same cycle, that drop wins: overflow[c] = 1 and drop_count = the number of drops in that cycle.

Optional Feature:
- Macro: TIMESTAMPER_FATAL_ON_OVERFLOW_EN.
- Defined: any drop additionally calls $fatal with the channel index at the edge where the drop occurs. This is simulation-only code.
- Undefined: drop / flag / count behaviour only, and the block is fully synthesizable.

Test Plan:
1. Single change: NUM_CHANNELS=1. Drive value 0 -> 0x5A in cycle 10 with ready=1 -> exactly one entry {data=0x5A, time=10, channel=0}, valid high in cycle 11 only.
2. Simultaneous changes: channels 0–3 all change in cycle 20, ready=1, RR pointer 0 -> four entries on cycles 21–24 in channel order 0,1,2,3, each with time=20.
3. Backpressure: hold ready=0 for 5 cycles while channel 2 then channel 1 change -> outputs stay frozen on channel 2's entry. After ready rises, channel 2's entry is accepted, then channel 1's.
4. Overflow: DEPTH=4, ready=0, toggle channel 0 on 6 consecutive cycles -> 4 entries buffered, overflow[0]=1, drop_count=2. After draining, data and time match the first 4 toggles.
5. Full with simultaneous pop/push: FIFO full, handshake in the same cycle as a new event -> event accepted, no overflow, count unchanged.
6. Reset and clear: assert reset_n=0 asynchronously mid-stream -> valid drops immediately and nothing replays. Separately, a clear_overflow pulse coincident with a drop -> overflow=1, drop_count=1.
